// File: rtl/syscall_unit_pkg.sv
// Shared syscall definitions: service codes, FSM state encoding and stall-source bits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package syscall_unit_pkg;

  // $v0 service codes understood by the unit
  localparam logic [31:0] SYS_CODE_PRINT = 32'd34;
  localparam logic [31:0] SYS_CODE_SLEEP = 32'd32;
  localparam logic [31:0] SYS_CODE_EXIT  = 32'd10;

  // FSM encoding
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_SLEEP = 2'd1,
    ST_HALT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Stall sources, OR-reduced into the pipeline stall
  localparam int STALL_SRC_W = 2;
  localparam int SRC_SLEEP   = 0;
  localparam int SRC_HALT    = 1;

endpackage

// File: rtl/syscall_sleep_timer.sv
// Loadable down-counter timing a sleep syscall; expire flags the final count.
// Latency: load visible next cycle; expire is combinational from the count.
// Backpressure: none; decrements only while dec_en and count is non-zero.
module syscall_sleep_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec_en,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins, otherwise decrement without ever wrapping below zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/syscall_unit.sv
// EX-stage syscall responder: print-hex, timed sleep, halt/resume. Optional macro SYSCALL_STATS_EN adds syscall_count.
// Latency: display_we one cycle after an accepted print; sleep stalls N+1 cycles; halt stalls until resume.
// Backpressure: drives stall combinationally; a DONE cycle follows each stall so the held syscall is not re-run.
module syscall_unit
  import syscall_unit_pkg::*;
#(
  parameter int unsigned SLEEP_SHIFT = 0,
  parameter int unsigned CNT_W       = 32,
  parameter logic [31:0] CODE_PRINT  = SYS_CODE_PRINT,
  parameter logic [31:0] CODE_SLEEP  = SYS_CODE_SLEEP,
  parameter logic [31:0] CODE_EXIT   = SYS_CODE_EXIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        syscall_en,
  input  logic [31:0] data_v0,
  input  logic [31:0] data_a0,
  input  logic        resume,
  output logic        stall,
  output logic        halted,
  output logic [31:0] display_data,
  output logic        display_we
`ifdef SYSCALL_STATS_EN
  ,
  output logic [31:0] syscall_count
`endif
);

  localparam int unsigned WIDE_W = (CNT_W > 32) ? CNT_W : 32;

  state_e                 state_q, state_d;
  logic                   halted_q, halted_d;
  logic [31:0]            display_data_q, display_data_d;
  logic                   display_we_q, display_we_d;
  logic [STALL_SRC_W-1:0] stall_src;
  logic                   tmr_load;
  logic                   tmr_dec;
  logic                   tmr_expire;
  logic [WIDE_W-1:0]      a0_wide;
  logic [CNT_W-1:0]       sleep_cnt;

  // Scale $a0 into sleep cycles, truncated to the counter width
  always_comb begin
    a0_wide   = WIDE_W'(data_a0) << SLEEP_SHIFT;
    sleep_cnt = a0_wide[CNT_W-1:0];
  end

  syscall_sleep_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (sleep_cnt),
    .dec_en   (tmr_dec),
    .expire   (tmr_expire)
  );

  // Next-state, stall sources and display update
  always_comb begin
    state_d        = state_q;
    halted_d       = halted_q;
    display_data_d = display_data_q;
    display_we_d   = 1'b0;
    stall_src      = '0;
    tmr_load       = 1'b0;
    tmr_dec        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (syscall_en) begin
          if (data_v0 == CODE_PRINT) begin
            display_data_d = data_a0;
            display_we_d   = 1'b1;
          end else if ((data_v0 == CODE_SLEEP) && (sleep_cnt != '0)) begin
            stall_src[SRC_SLEEP] = 1'b1;
            tmr_load             = 1'b1;
            state_d              = ST_SLEEP;
          end else if (data_v0 == CODE_EXIT) begin
            stall_src[SRC_HALT] = 1'b1;
            halted_d            = 1'b1;
            state_d             = ST_HALT;
          end
        end
      end
      ST_SLEEP: begin
        stall_src[SRC_SLEEP] = 1'b1;
        tmr_dec              = 1'b1;
        if (tmr_expire) begin
          state_d = ST_DONE;
        end
      end
      ST_HALT: begin
        stall_src[SRC_HALT] = 1'b1;
        halted_d            = 1'b1;
        if (resume) begin
          halted_d = 1'b0;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        // Release cycle: the still-held syscall is ignored here
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      halted_q       <= 1'b0;
      display_data_q <= '0;
      display_we_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      halted_q       <= halted_d;
      display_data_q <= display_data_d;
      display_we_q   <= display_we_d;
    end
  end

  assign stall        = |stall_src;
  assign halted       = halted_q;
  assign display_data = display_data_q;
  assign display_we   = display_we_q;

`ifdef SYSCALL_STATS_EN
  logic [31:0] syscall_count_q, syscall_count_d;

  // Count every syscall accepted in IDLE, no-ops included
  always_comb begin
    syscall_count_d = syscall_count_q;
    if ((state_q == ST_IDLE) && syscall_en) begin
      syscall_count_d = syscall_count_q + 32'd1;
    end
  end

  // Statistics register, wraps modulo 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      syscall_count_q <= '0;
    end else begin
      syscall_count_q <= syscall_count_d;
    end
  end

  assign syscall_count = syscall_count_q;
`endif

endmodule

// File: tb/tb_syscall_unit.sv
// Self-checking bench for syscall_unit: vector table for IDLE services plus sleep/halt/reset sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_syscall_unit;
  import syscall_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        syscall_en;
  logic [31:0] data_v0;
  logic [31:0] data_a0;
  logic        resume;
  logic        stall;
  logic        halted;
  logic [31:0] display_data;
  logic        display_we;
`ifdef SYSCALL_STATS_EN
  logic [31:0] syscall_count;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] v0;
    logic [31:0] a0;
    logic        exp_stall;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [31:0] data;
  } exp_out_t;

  localparam int NV = 7;
  vec_t     vecs [NV];
  exp_out_t sb [$];

  syscall_unit dut (
    .clk          (clk),
    .rst          (rst),
    .syscall_en   (syscall_en),
    .data_v0      (data_v0),
    .data_a0      (data_a0),
    .resume       (resume),
    .stall        (stall),
    .halted       (halted),
    .display_data (display_data),
    .display_we   (display_we)
`ifdef SYSCALL_STATS_EN
    ,
    .syscall_count(syscall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Sleep with en held until the release cycle; n counts stalled cycles
  task automatic run_sleep(input logic [31:0] a0, input int exp_n);
    int n;
    n = 0;
    @(negedge clk);
    syscall_en = 1'b1;
    data_v0    = 32'd32;
    data_a0    = a0;
    #1;
    while ((stall === 1'b1) && (n < 500)) begin
      n++;
      @(negedge clk);
      #1;
    end
    check($sformatf("sleep%0d_stall_cycles", a0), n, exp_n);
    check($sformatf("sleep%0d_done_state", a0), dut.state_q, ST_DONE);
    @(negedge clk);
    syscall_en = 1'b0;
    #1;
    check($sformatf("sleep%0d_no_retrigger", a0), stall, 1'b0);
    check($sformatf("sleep%0d_idle", a0), dut.state_q, ST_IDLE);
  endtask

  task automatic reset_and_check(input string name);
    @(negedge clk);
    rst        = 1'b1;
    syscall_en = 1'b0;
    resume     = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_state"}, dut.state_q, ST_IDLE);
    check({name, "_stall"}, stall, 1'b0);
    check({name, "_halted"}, halted, 1'b0);
    check({name, "_counter"}, dut.u_timer.cnt_q, 32'd0);
    check({name, "_disp_data"}, display_data, 32'd0);
    check({name, "_disp_we"}, display_we, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_out_t e;
    int bad;

    vecs[0] = '{32'd34,         32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[1] = '{32'd32,         32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{32'd5,          32'd1234,     1'b0, 1'b0, 32'hDEADBEEF};
    vecs[3] = '{32'd0,          32'hFFFFFFFF, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[4] = '{32'd34,         32'h12345678, 1'b0, 1'b1, 32'h12345678};
    vecs[5] = '{32'h80000022,   32'd7,        1'b0, 1'b0, 32'h12345678};
    vecs[6] = '{32'd34,         32'hA5A50001, 1'b0, 1'b1, 32'hA5A50001};

    rst        = 1'b1;
    syscall_en = 1'b0;
    resume     = 1'b0;
    data_v0    = '0;
    data_a0    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_disp_data", display_data, 32'd0);
    check("rst_disp_we", display_we, 1'b0);
    check("rst_counter", dut.u_timer.cnt_q, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle IDLE services from the vector table
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      syscall_en = 1'b1;
      data_v0    = vecs[i].v0;
      data_a0    = vecs[i].a0;
      #1;
      check($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
      sb.push_back('{we: vecs[i].exp_we, data: vecs[i].exp_data});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("vec%0d_we", i), display_we, e.we);
      check($sformatf("vec%0d_data", i), display_data, e.data);
      @(negedge clk);
      syscall_en = 1'b0;
      #1;
      check($sformatf("vec%0d_stall_after", i), stall, 1'b0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_we_clear", i), display_we, 1'b0);
    end

    // Sleep: N+1 stalled cycles, then a release cycle without re-execution
    run_sleep(32'd3, 4);
    run_sleep(32'd1, 2);

    // Halt holds indefinitely, even if syscall_en drops mid-halt
    @(negedge clk);
    syscall_en = 1'b1;
    data_v0    = 32'd10;
    data_a0    = 32'd0;
    #1;
    check("halt_entry_stall", stall, 1'b1);
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      syscall_en = !((c >= 50) && (c < 80));
      #1;
      if ((stall !== 1'b1) || (halted !== 1'b1)) bad++;
    end
    check("halt_hold_100_bad_cycles", bad, 0);
    @(negedge clk);
    resume = 1'b1;
    #1;
    check("halt_resume_cycle_stall", stall, 1'b1);
    @(negedge clk);
    resume = 1'b0;
    #1;
    check("halt_resume_halted", halted, 1'b0);
    check("halt_resume_done_stall", stall, 1'b0);
    check("halt_resume_done_state", dut.state_q, ST_DONE);
    @(negedge clk);
    syscall_en = 1'b0;
    #1;
    check("halt_back_idle", dut.state_q, ST_IDLE);
    check("halt_back_idle_stall", stall, 1'b0);
    @(negedge clk);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    #1;
    check("resume_in_idle_halted", halted, 1'b0);
    check("resume_in_idle_state", dut.state_q, ST_IDLE);
    check("display_kept", display_data, 32'hA5A50001);

    // Reset in the middle of a long sleep
    @(negedge clk);
    syscall_en = 1'b1;
    data_v0    = 32'd32;
    data_a0    = 32'd100;
    repeat (10) @(negedge clk);
    #1;
    check("pre_rst_sleep_stall", stall, 1'b1);
    reset_and_check("rst_sleep");

    // Reset while halted
    @(negedge clk);
    syscall_en = 1'b1;
    data_v0    = 32'd10;
    repeat (5) @(negedge clk);
    #1;
    check("pre_rst_halted", halted, 1'b1);
    reset_and_check("rst_halt");

`ifdef SYSCALL_STATS_EN
    check("stats_rst", syscall_count, 32'd0);
    @(negedge clk);
    syscall_en = 1'b1;
    data_v0    = 32'd34;
    data_a0    = 32'h1;
    @(negedge clk);
    syscall_en = 1'b0;
    run_sleep(32'd2, 3);
    @(negedge clk);
    syscall_en = 1'b1;
    data_v0    = 32'd5;
    @(negedge clk);
    data_v0    = 32'd10;
    repeat (4) @(negedge clk);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    @(negedge clk);
    syscall_en = 1'b0;
    #1;
    check("stats_count", syscall_count, 32'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
